// File: rtl/acc_hub_pkg.sv
// Shared types and defaults for the accelerator channel hub.
package acc_hub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } hub_state_e;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefDepth = 16;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push on full and pop on empty are dropped.
module sync_fifo
  import acc_hub_pkg::*;
#(
  parameter int unsigned Dw    = DefDw,
  parameter int unsigned Depth = DefDepth
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [Dw-1:0] din_i,
  input  logic          pop_i,
  output logic [Dw-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = ptr_width(Depth);

  logic [Dw-1:0]   mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Full is judged before any same-cycle pop, so a push on full is always dropped.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  // Pointer advance; natural wrap at 2*Depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
  end

  // Pointer registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/acc_channel_hub.sv
// Router-side streaming port fanned out to NCh accelerator FIFO pairs, with job control FSM.
module acc_channel_hub
  import acc_hub_pkg::*;
#(
  parameter int unsigned NCh   = 2,
  parameter int unsigned Dw    = DefDw,
  parameter int unsigned Depth = DefDepth,
  parameter int unsigned CntW  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [2:0]        ch_sel_i,
  input  logic              bypass_i,
  input  logic [CntW-1:0]   word_count_i,
  input  logic              tx_valid_i,
  input  logic [Dw-1:0]     tx_data_i,
  output logic              tx_ready_o,
  output logic              rx_valid_o,
  output logic [Dw-1:0]     rx_data_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_sel_o,
  output logic [NCh-1:0]    acc_enable_o,
  input  logic [NCh-1:0]    acc_get_i,
  output logic [NCh*Dw-1:0] acc_data_out_o,
  output logic [NCh-1:0]    to_acc_empty_o,
  input  logic [NCh-1:0]    acc_put_i,
  input  logic [NCh*Dw-1:0] acc_data_in_i,
  output logic [NCh-1:0]    from_acc_full_o,
  output logic [NCh-1:0]    ovf_err_o
);

  localparam int unsigned ChW = (NCh > 1) ? $clog2(NCh) : 1;

  hub_state_e      state_q;
  logic [ChW-1:0]  ch_q;
  logic            bypass_q;
  logic [CntW-1:0] count_q, sent_q, recv_q;
  logic            done_q, err_sel_q;
  logic [NCh-1:0]  ovf_q, ovf_d, ovf_set;

  logic [NCh-1:0]  to_push, to_full, to_empty;
  logic [NCh-1:0]  from_push, from_pop, from_full, from_empty;
  logic [NCh-1:0]  ch_hit, byp_hit;
  logic [Dw-1:0]   to_head   [NCh];
  logic [Dw-1:0]   from_head [NCh];
  logic [Dw-1:0]   from_din  [NCh];

  logic run, sel_valid, job_start, tx_xfer, rx_xfer;

  assign run       = (state_q == StRun);
  assign sel_valid = (32'(ch_sel_i) < NCh);
  assign job_start = (state_q == StIdle) & start_i & sel_valid;

  // In bypass the from-FIFO is the only buffer, so its fullness gates the router.
  assign tx_ready_o = run & (sent_q < count_q) &
                      ~(bypass_q ? from_full[ch_q] : to_full[ch_q]);
  assign rx_valid_o = run & ~from_empty[ch_q] & (recv_q < count_q);
  assign rx_data_o  = from_empty[ch_q] ? '0 : from_head[ch_q];
  assign tx_xfer    = tx_valid_i & tx_ready_o;
  assign rx_xfer    = rx_valid_o & rx_ready_i;

  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign err_sel_o       = err_sel_q;
  assign ovf_err_o       = ovf_q;
  assign to_acc_empty_o  = to_empty;
  assign from_acc_full_o = from_full;

  // Channel demux/mux: router traffic only reaches the latched channel during a job.
  always_comb begin
    ch_hit         = '0;
    byp_hit        = '0;
    to_push        = '0;
    from_push      = '0;
    from_pop       = '0;
    ovf_set        = '0;
    acc_enable_o   = '0;
    acc_data_out_o = '0;
    for (int unsigned i = 0; i < NCh; i++) begin
      from_din[i]       = acc_data_in_i[i*Dw +: Dw];
      ch_hit[i]         = busy_o && (ch_q == ChW'(i));
      byp_hit[i]        = ch_hit[i] & bypass_q;
      to_push[i]        = tx_xfer & ch_hit[i] & ~bypass_q;
      from_pop[i]       = rx_xfer & ch_hit[i];
      acc_enable_o[i]   = run & ch_hit[i] & ~bypass_q;
      acc_data_out_o[i*Dw +: Dw] = to_empty[i] ? '0 : to_head[i];
      // A bypass job owns the from-FIFO write port; accelerator puts are ignored.
      if (byp_hit[i]) begin
        from_push[i] = tx_xfer;
        from_din[i]  = tx_data_i;
      end else begin
        from_push[i] = acc_put_i[i];
        ovf_set[i]   = acc_put_i[i] & from_full[i];
      end
    end
  end

  // Sticky overflow: set on put-while-full, cleared when a job starts on that channel.
  always_comb begin
    ovf_d = ovf_q | ovf_set;
    if (job_start) begin
      ovf_d[ch_sel_i[ChW-1:0]] = 1'b0;
    end
  end

  // Overflow flag registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Job FSM with word counters and registered done/err_sel pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      bypass_q  <= 1'b0;
      count_q   <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      done_q    <= 1'b0;
      err_sel_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_sel_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (sel_valid) begin
              ch_q     <= ch_sel_i[ChW-1:0];
              bypass_q <= bypass_i;
              count_q  <= word_count_i;
              sent_q   <= '0;
              recv_q   <= '0;
              if (word_count_i == '0) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRun;
              end
            end else begin
              err_sel_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (tx_xfer) sent_q <= sent_q + CntW'(1);
          if (rx_xfer) recv_q <= recv_q + CntW'(1);
          // Leave on the cycle of the final pop.
          if ((recv_q + CntW'(rx_xfer)) == count_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NCh; g++) begin : g_ch
    sync_fifo #(
      .Dw    (Dw),
      .Depth (Depth)
    ) u_to_acc (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (to_push[g]),
      .din_i   (tx_data_i),
      .pop_i   (acc_get_i[g]),
      .dout_o  (to_head[g]),
      .full_o  (to_full[g]),
      .empty_o (to_empty[g])
    );

    sync_fifo #(
      .Dw    (Dw),
      .Depth (Depth)
    ) u_from_acc (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (from_push[g]),
      .din_i   (from_din[g]),
      .pop_i   (from_pop[g]),
      .dout_o  (from_head[g]),
      .full_o  (from_full[g]),
      .empty_o (from_empty[g])
    );
  end

endmodule

// File: tb/tb_acc_channel_hub.sv
// Directed bench for acc_channel_hub: two channels, four-entry FIFOs.
module tb_acc_channel_hub;

  localparam int unsigned NCh   = 2;
  localparam int unsigned Dw    = 32;
  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        ch_sel;
  logic              bypass;
  logic [CntW-1:0]   word_count;
  logic              tx_valid;
  logic [Dw-1:0]     tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [Dw-1:0]     rx_data;
  logic              rx_ready;
  logic              busy;
  logic              done;
  logic              err_sel;
  logic [NCh-1:0]    acc_enable;
  logic [NCh-1:0]    acc_get;
  logic [NCh*Dw-1:0] acc_data_out;
  logic [NCh-1:0]    to_acc_empty;
  logic [NCh-1:0]    acc_put;
  logic [NCh*Dw-1:0] acc_data_in;
  logic [NCh-1:0]    from_acc_full;
  logic [NCh-1:0]    ovf_err;

  // Accelerator model: optional x+1 loop on channel 0, otherwise manual get/put.
  logic       loop_en;
  logic [1:0] get_drv, put_drv;
  assign acc_get     = loop_en ? {1'b0, ~to_acc_empty[0]} : get_drv;
  assign acc_put     = loop_en ? {1'b0, ~to_acc_empty[0]} : put_drv;
  assign acc_data_in = {acc_data_out[63:32] + 32'd1, acc_data_out[31:0] + 32'd1};

  always #5 clk = ~clk;

  acc_channel_hub #(
    .NCh   (NCh),
    .Dw    (Dw),
    .Depth (Depth),
    .CntW  (CntW)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .ch_sel_i        (ch_sel),
    .bypass_i        (bypass),
    .word_count_i    (word_count),
    .tx_valid_i      (tx_valid),
    .tx_data_i       (tx_data),
    .tx_ready_o      (tx_ready),
    .rx_valid_o      (rx_valid),
    .rx_data_o       (rx_data),
    .rx_ready_i      (rx_ready),
    .busy_o          (busy),
    .done_o          (done),
    .err_sel_o       (err_sel),
    .acc_enable_o    (acc_enable),
    .acc_get_i       (acc_get),
    .acc_data_out_o  (acc_data_out),
    .to_acc_empty_o  (to_acc_empty),
    .acc_put_i       (acc_put),
    .acc_data_in_i   (acc_data_in),
    .from_acc_full_o (from_acc_full),
    .ovf_err_o       (ovf_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Current job description and progress.
  int          j_ch, j_n, tx_idx, rx_idx, done_cnt;
  logic        j_byp, j_tx_en, s_busy;
  logic [31:0] j_base, j_step, j_offs;

  // One clock: sample at negedge, then advance the router driver after posedge.
  task automatic step();
    logic       tx_f, rx_f;
    logic [1:0] en_exp;
    @(negedge clk);
    tx_f = tx_valid & tx_ready;
    rx_f = rx_valid & rx_ready;
    if (rx_f) begin
      check_eq("rx_data", rx_data, j_base + rx_idx * j_step + j_offs);
      rx_idx++;
    end
    if (done) done_cnt++;
    en_exp = (busy && !done && !j_byp) ? 2'(1 << j_ch) : 2'b00;
    check_eq("acc_enable", acc_enable, en_exp);
    if (j_byp) check_eq("to_acc_empty_byp", to_acc_empty[j_ch], 1'b1);
    s_busy = busy;
    @(posedge clk);
    #1;
    if (tx_f) tx_idx++;
    tx_valid = j_tx_en && (tx_idx < j_n);
    tx_data  = j_base + tx_idx;
  endtask

  task automatic begin_job(input int ch, input logic byp, input int n, input logic [31:0] base,
                           input logic [31:0] stp, input logic [31:0] offs, input logic tx_en);
    j_ch = ch; j_byp = byp; j_n = n; j_base = base; j_step = stp; j_offs = offs;
    j_tx_en = tx_en; tx_idx = 0; rx_idx = 0; done_cnt = 0; s_busy = 1'b1;
    start      = 1'b1;
    ch_sel     = 3'(ch);
    bypass     = byp;
    word_count = 16'(n);
    tx_valid   = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    tx_valid = tx_en && (n > 0);
    tx_data  = base;
  endtask

  task automatic finish_job(input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc && !(done_cnt > 0 && !s_busy)) begin
      step();
      cyc++;
    end
    check_eq("job_ends", (done_cnt > 0 && !s_busy), 1'b1);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("rx_count", rx_idx, j_n);
    check_eq("tx_count", tx_idx, j_tx_en ? j_n : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic saw_done;
    reset = 1'b1; start = 1'b0; ch_sel = '0; bypass = 1'b0; word_count = '0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    loop_en = 1'b0; get_drv = '0; put_drv = '0;
    j_ch = 0; j_byp = 1'b0; j_n = 0; j_base = '0; j_step = '0; j_offs = '0; j_tx_en = 1'b0;
    tx_idx = 0; rx_idx = 0; done_cnt = 0; s_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_tx_ready", tx_ready, 1'b0);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_rx_data", rx_data, 32'h0);
    check_eq("rst_busy_done_err", {busy, done, err_sel}, 3'b000);
    check_eq("rst_acc_enable", acc_enable, 2'b00);
    check_eq("rst_to_acc_empty", to_acc_empty, 2'b11);
    check_eq("rst_from_acc_full", from_acc_full, 2'b00);
    check_eq("rst_ovf_err", ovf_err, 2'b00);
    @(posedge clk);
    #1;

    // 1: ch0 job through x+1 accelerator loop
    loop_en  = 1'b1;
    rx_ready = 1'b1;
    begin_job(0, 1'b0, 4, 32'h10, 32'd1, 32'd1, 1'b1);
    finish_job(60, cyc);

    // 2: bypass job on ch1
    loop_en = 1'b0;
    begin_job(1, 1'b1, 3, 32'hA, 32'd1, 32'd0, 1'b1);
    finish_job(60, cyc);

    // 3: stalled accelerator backpressures the router after Depth words
    begin_job(0, 1'b0, 8, 32'h30, 32'd1, 32'd1, 1'b1);
    repeat (10) step();
    check_eq("stall_sent", tx_idx, 4);
    check_eq("stall_tx_ready", tx_ready, 1'b0);
    get_drv = 2'b01;
    put_drv = 2'b01;
    step();
    get_drv = 2'b00;
    put_drv = 2'b00;
    step();
    check_eq("resume_sent", tx_idx, 5);
    loop_en = 1'b1;
    finish_job(120, cyc);

    // 4: overflow of from-FIFO ch0 outside a job
    loop_en  = 1'b0;
    rx_ready = 1'b0;
    put_drv  = 2'b01;
    repeat (8) @(posedge clk);
    #1;
    put_drv = 2'b00;
    @(negedge clk);
    check_eq("ovf_full", from_acc_full, 2'b01);
    check_eq("ovf_set", ovf_err, 2'b01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("ovf_sticky", ovf_err, 2'b01);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    begin_job(0, 1'b0, 4, 32'h0, 32'd0, 32'd1, 1'b0);
    check_eq("ovf_cleared", ovf_err, 2'b00);
    finish_job(60, cyc);
    check_eq("ovf_drained", from_acc_full, 2'b00);

    // 5: invalid channel, then zero-length job
    start = 1'b1; ch_sel = 3'd5; word_count = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("err_sel_pulse", {err_sel, busy}, 2'b10);
    @(negedge clk);
    check_eq("err_sel_gone", {err_sel, busy}, 2'b00);
    @(posedge clk);
    #1;
    begin_job(0, 1'b0, 0, 32'h50, 32'd1, 32'd0, 1'b1);
    finish_job(10, cyc);
    check_eq("zero_cnt_latency", cyc, 2);

    // 6: reset mid-job aborts without done, then a fresh job runs
    loop_en = 1'b1;
    begin_job(0, 1'b0, 6, 32'h60, 32'd1, 32'd1, 1'b1);
    for (int k = 0; k < 40 && tx_idx < 2; k++) step();
    check_eq("abort_sent", tx_idx, 2);
    reset    = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_busy_done", {busy, done}, 2'b00);
    check_eq("abort_to_empty", to_acc_empty, 2'b11);
    check_eq("abort_from_full", from_acc_full, 2'b00);
    check_eq("abort_rx_tx", {rx_valid, tx_ready}, 2'b00);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_eq("abort_no_done", saw_done, 1'b0);
    @(posedge clk);
    #1;
    begin_job(0, 1'b0, 6, 32'h70, 32'd1, 32'd1, 1'b1);
    finish_job(80, cyc);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
